// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: FSM encoding and stage counts.
package pipe_pkg;
  localparam int NUM_STAGES = 5;              // pc plus four pipeline registers
  localparam int NUM_PREGS  = NUM_STAGES - 1;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MULDIV    = 2'd1,
    MD_HOLD   = 2'd2,
    EXC_DRAIN = 2'd3
  } pipe_state_e;
endpackage

// File: rtl/pipeline_ctrl.sv
// Central hazard controller: per-register stall/flush, mul/div sequencing,
// exception redirect and a free-running stall-cycle counter.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] STALL_CNT_RST = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_flush,
  input  logic        dmem_stall,
  input  logic        muldiv_start,
  input  logic        muldiv_done,
  input  logic        load_use,
  input  logic        ifetch_stall,
  output logic        pc_stall,
  output logic        IF_ID_Stall,
  output logic        ID_EXE_Stall,
  output logic        EXE_MEM_Stall,
  output logic        MEM_WB_Stall,
  output logic        IF_ID_Flush,
  output logic        ID_EXE_Flush,
  output logic        EXE_MEM_Flush,
  output logic        MEM_WB_Flush,
  output logic        muldiv_go,
  output logic        muldiv_cancel,
  output logic        pc_redirect,
  output logic [31:0] stall_cnt
);

  pipe_state_e           state_q, state_d;
  logic [NUM_STAGES-1:0] stall_v;  // [0]=pc, [1]=IF_ID .. [4]=MEM_WB
  logic [NUM_PREGS-1:0]  flush_v;  // [0]=IF_ID .. [3]=MEM_WB
  logic                  exc_pend;

  always_comb begin
    stall_v       = '0;
    flush_v       = '0;
    muldiv_go     = 1'b0;
    muldiv_cancel = 1'b0;
    pc_redirect   = 1'b0;
    state_d       = state_q;
    exc_pend      = exc_flush || (state_q == EXC_DRAIN);

    if (exc_pend) begin
      muldiv_cancel = (state_q == MULDIV) || (state_q == MD_HOLD);
      // Redirect only once fetch is quiet, otherwise freeze everything and wait.
      if (ifetch_stall) begin
        stall_v = '1;
        state_d = EXC_DRAIN;
      end else begin
        flush_v     = '1;
        pc_redirect = 1'b1;
        state_d     = RUN;
      end
    end else if (dmem_stall) begin
      stall_v[3:0]         = 4'b1111;
      flush_v[NUM_PREGS-1] = 1'b1;
      if (state_q == MULDIV && muldiv_done) state_d = MD_HOLD;
    end else begin
      case (state_q)
        RUN: begin
          if (muldiv_start) begin
            muldiv_go    = 1'b1;
            stall_v[2:0] = 3'b111;
            flush_v[2]   = 1'b1;
            state_d      = MULDIV;
          end else if (load_use) begin
            stall_v[1:0] = 2'b11;
            flush_v[1]   = 1'b1;
          end else if (ifetch_stall) begin
            stall_v[0] = 1'b1;
            flush_v[0] = 1'b1;
          end
        end
        MULDIV: begin
          if (muldiv_done) begin
            state_d = RUN;
          end else begin
            stall_v[2:0] = 3'b111;
            flush_v[2]   = 1'b1;
          end
        end
        MD_HOLD: state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  assign pc_stall      = stall_v[0];
  assign IF_ID_Stall   = stall_v[1];
  assign ID_EXE_Stall  = stall_v[2];
  assign EXE_MEM_Stall = stall_v[3];
  assign MEM_WB_Stall  = stall_v[4];
  assign IF_ID_Flush   = flush_v[0];
  assign ID_EXE_Flush  = flush_v[1];
  assign EXE_MEM_Flush = flush_v[2];
  assign MEM_WB_Flush  = flush_v[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      stall_cnt <= STALL_CNT_RST;
    end else begin
      state_q <= state_d;
      if (stall_v[0]) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scenario bench for pipeline_ctrl: per-cycle expected control vectors are
// queued as stimulus is applied and checked against the combinational outputs.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic exc_flush = 1'b0, dmem_stall = 1'b0, muldiv_start = 1'b0;
  logic muldiv_done = 1'b0, load_use = 1'b0, ifetch_stall = 1'b0;

  logic pc_stall, IF_ID_Stall, ID_EXE_Stall, EXE_MEM_Stall, MEM_WB_Stall;
  logic IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, MEM_WB_Flush;
  logic muldiv_go, muldiv_cancel, pc_redirect;
  logic [31:0] stall_cnt;

  logic w_pc, w_ifs, w_ids, w_exs, w_mws, w_iff, w_idf, w_exf, w_mwf, w_go, w_cn, w_rd;
  logic [31:0] w_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl u_dut (
    .clk(clk), .rst(rst), .exc_flush(exc_flush), .dmem_stall(dmem_stall),
    .muldiv_start(muldiv_start), .muldiv_done(muldiv_done), .load_use(load_use),
    .ifetch_stall(ifetch_stall), .pc_stall(pc_stall), .IF_ID_Stall(IF_ID_Stall),
    .ID_EXE_Stall(ID_EXE_Stall), .EXE_MEM_Stall(EXE_MEM_Stall), .MEM_WB_Stall(MEM_WB_Stall),
    .IF_ID_Flush(IF_ID_Flush), .ID_EXE_Flush(ID_EXE_Flush), .EXE_MEM_Flush(EXE_MEM_Flush),
    .MEM_WB_Flush(MEM_WB_Flush), .muldiv_go(muldiv_go), .muldiv_cancel(muldiv_cancel),
    .pc_redirect(pc_redirect), .stall_cnt(stall_cnt)
  );

  // Counter preset one step below wrap, sharing the same stimulus.
  pipeline_ctrl #(.STALL_CNT_RST(32'hFFFF_FFFF)) u_wrap (
    .clk(clk), .rst(rst), .exc_flush(exc_flush), .dmem_stall(dmem_stall),
    .muldiv_start(muldiv_start), .muldiv_done(muldiv_done), .load_use(load_use),
    .ifetch_stall(ifetch_stall), .pc_stall(w_pc), .IF_ID_Stall(w_ifs),
    .ID_EXE_Stall(w_ids), .EXE_MEM_Stall(w_exs), .MEM_WB_Stall(w_mws),
    .IF_ID_Flush(w_iff), .ID_EXE_Flush(w_idf), .EXE_MEM_Flush(w_exf),
    .MEM_WB_Flush(w_mwf), .muldiv_go(w_go), .muldiv_cancel(w_cn),
    .pc_redirect(w_rd), .stall_cnt(w_cnt)
  );

  // Output vector: pc,IFID_s,IDEXE_s,EXMEM_s,MEMWB_s,IFID_f,IDEXE_f,EXMEM_f,MEMWB_f,go,cancel,redirect
  logic [11:0] outs;
  assign outs = {pc_stall, IF_ID_Stall, ID_EXE_Stall, EXE_MEM_Stall, MEM_WB_Stall,
                 IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, MEM_WB_Flush,
                 muldiv_go, muldiv_cancel, pc_redirect};

  localparam logic [11:0] E_NONE  = 12'h000;
  localparam logic [11:0] E_LU    = 12'hC20;
  localparam logic [11:0] E_IF    = 12'h840;
  localparam logic [11:0] E_DM    = 12'hF08;
  localparam logic [11:0] E_MDGO  = 12'hE14;
  localparam logic [11:0] E_MD    = 12'hE10;
  localparam logic [11:0] E_EXC   = 12'h079;
  localparam logic [11:0] E_DRAIN = 12'hF80;
  localparam logic [11:0] E_DRCAN = 12'hF82;
  localparam logic [11:0] E_EXCAN = 12'h07B;

  // Input vector: exc, dmem, start, done, load_use, ifetch
  localparam logic [5:0] I_0   = 6'b000000;
  localparam logic [5:0] I_IFS = 6'b000001;
  localparam logic [5:0] I_LU  = 6'b000010;
  localparam logic [5:0] I_DN  = 6'b000100;
  localparam logic [5:0] I_ST  = 6'b001000;
  localparam logic [5:0] I_DM  = 6'b010000;
  localparam logic [5:0] I_EXC = 6'b100000;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic [11:0] exp_q[$];

  task automatic step(input string tag, input logic [5:0] in, input logic [11:0] exp);
    logic [11:0] e;
    @(negedge clk);
    {exc_flush, dmem_stall, muldiv_start, muldiv_done, load_use, ifetch_stall} = in;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (outs !== e) begin
      errors++;
      $display("FAIL %s outputs: got %03h expected %03h", tag, outs, e);
    end
    checks++;
    if (stall_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s stall_cnt: got %0d expected %0d", tag, stall_cnt, exp_cnt);
    end
    if (e[11]) exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic test_reset(input string tag);
    @(negedge clk);
    {exc_flush, dmem_stall, muldiv_start, muldiv_done, load_use, ifetch_stall} = I_0;
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== 12'h000) begin
      errors++;
      $display("FAIL %s reset outputs: got %03h expected 000", tag, outs);
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL %s reset stall_cnt: got %0d expected 0", tag, stall_cnt);
    end
    checks++;
    if (w_cnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL %s reset preset cnt: got %08h expected ffffffff", tag, w_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 32'd0;
  endtask

  task automatic test_load_use;
    step("lu_cycle", I_LU, E_LU);
    step("lu_after", I_0, E_NONE);
    step("ifetch", I_IFS, E_IF);
    step("ifetch_after", I_0, E_NONE);
  endtask

  task automatic test_priority;
    step("pri_dmem", I_DM | I_ST | I_LU | I_IFS, E_DM);
    step("pri_start_ignored", I_0, E_NONE);
    step("pri_lu_over_if", I_LU | I_IFS, E_LU);
    step("pri_exc_run", I_EXC | I_DM | I_ST | I_LU, E_EXC);
    step("pri_exc_after", I_0, E_NONE);
    step("pri_exc_drain", I_EXC | I_DM | I_IFS, E_DRAIN);
    step("pri_drain_flush", I_DM, E_EXC);
    step("pri_drain_done", I_0, E_NONE);
  endtask

  task automatic test_muldiv;
    step("md_go", I_ST, E_MDGO);
    step("md_wait1", I_0, E_MD);
    step("md_wait2_start_ign", I_ST, E_MD);
    step("md_wait3", I_0, E_MD);
    step("md_done", I_DN, E_NONE);
    step("md_back_run", I_LU, E_LU);
    step("md2_go", I_ST, E_MDGO);
    step("md2_dmem", I_DM, E_DM);
    step("md2_wait", I_LU, E_MD);
    step("md2_done", I_DN, E_NONE);
    step("md2_idle", I_0, E_NONE);
  endtask

  task automatic test_md_hold;
    step("hold_go", I_ST, E_MDGO);
    step("hold_wait", I_0, E_MD);
    step("hold_done_dmem", I_DN | I_DM, E_DM);
    step("hold_1", I_DM | I_ST, E_DM);
    step("hold_2", I_DM, E_DM);
    step("hold_3", I_DM | I_LU, E_DM);
    step("hold_release", I_ST, E_NONE);
    step("hold_run", I_LU, E_LU);
  endtask

  task automatic test_exc_muldiv;
    step("exc_go", I_ST, E_MDGO);
    step("exc_wait", I_0, E_MD);
    step("exc_cancel", I_EXC | I_IFS, E_DRCAN);
    step("exc_drain", I_IFS | I_DN, E_DRAIN);
    step("exc_flush", I_0, E_EXC);
    step("exc_run", I_LU, E_LU);
    step("exc2_go", I_ST, E_MDGO);
    step("exc2_cancel_now", I_EXC, E_EXCAN);
    step("exc2_run", I_0, E_NONE);
  endtask

  task automatic test_wrap;
    test_reset("wrap");
    step("wrap_stall", I_LU, E_LU);
    step("wrap_after", I_0, E_NONE);
    checks++;
    if (w_cnt !== 32'd0) begin
      errors++;
      $display("FAIL wrap stall_cnt: got %08h expected 00000000", w_cnt);
    end
  endtask

  task automatic test_reset_mid;
    step("rm_go", I_ST, E_MDGO);
    step("rm_wait", I_0, E_MD);
    test_reset("mid_muldiv");
    step("rm_run", I_LU, E_LU);
    step("rm_exc", I_EXC | I_IFS, E_DRAIN);
    test_reset("mid_drain");
    step("rm_run2", I_LU, E_LU);
    step("rm_idle", I_0, E_NONE);
  endtask

  initial begin
    test_reset("initial");
    test_load_use();
    test_priority();
    test_muldiv();
    test_md_hold();
    test_exc_muldiv();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: exc_flush  in  1  exception/eret committed in MEM.
REQ-004 SHALL have: dmem_stall  in  1  D-side access in MEM not complete.
REQ-005 SHALL have: muldiv_start  in  1  EXE holds multi-cycle mul/div.
REQ-006 SHALL have: muldiv_done  in  1  mul/div unit result valid (1-cycle pulse).
REQ-007 SHALL have: load_use  in  1  ID depends on load in EXE.
REQ-008 SHALL have: ifetch_stall  in  1  I-side fetch not complete.
REQ-009 SHALL have: pc_stall, IF_ID_Stall, ID_EXE_Stall, EXE_MEM_Stall, MEM_WB_Stall  out  1 each  hold that register.
REQ-010 SHALL have: IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, MEM_WB_Flush  out  1 each  load bubble.
REQ-011 SHALL have: muldiv_go  out  1  start pulse; muldiv_cancel  out  1  abort pulse; pc_redirect  out  1  take exception vector.
REQ-012 SHALL have: stall_cnt  out  32  cycles with pc_stall high.

Function
REQ-013 SHALL implement FSM states RUN, MULDIV, MD_HOLD, EXC_DRAIN; outputs combinational from state and inputs.
REQ-014 SHALL never assert Stall and Flush of the same register in one cycle.
REQ-015 SHALL apply priority exc_flush > dmem_stall > mul/div > load_use > ifetch_stall.
REQ-016 Exception, ifetch_stall low: assert all four Flush and pc_redirect for one cycle, no Stall; next state RUN.
REQ-017 Exception, ifetch_stall high: next state EXC_DRAIN; there pc_stall and all Stall high until ifetch_stall low, then REQ-016 cycle, then RUN.
REQ-018 Exception in MULDIV or MD_HOLD: muldiv_cancel pulse same cycle, then REQ-016/017.
REQ-019 dmem_stall (no exception): pc_stall, IF_ID_Stall, ID_EXE_Stall, EXE_MEM_Stall high; MEM_WB_Flush high.
REQ-020 RUN, muldiv_start, no dmem_stall: muldiv_go one cycle; next MULDIV; pc/IF_ID/ID_EXE Stall high, EXE_MEM_Flush high that cycle.
REQ-021 MULDIV without done: same outputs as REQ-020 minus muldiv_go.
REQ-022 MULDIV, done, no dmem_stall: no Stall/Flush, EXE advances; next RUN.
REQ-023 MULDIV, done, dmem_stall: next MD_HOLD; apply REQ-019 until dmem_stall low, then release as REQ-022; muldiv_go never reasserted.
REQ-024 muldiv_start SHALL be ignored outside RUN and in cycle dmem_stall or exc_flush is high.
REQ-025 load_use (RUN, nothing higher): pc_stall, IF_ID_Stall high; ID_EXE_Flush high.
REQ-026 ifetch_stall only: pc_stall high; IF_ID_Flush high.
REQ-027 stall_cnt SHALL increment by 1 each cycle pc_stall high; wraps 0xFFFFFFFF -> 0.

Reset
REQ-028 On rst: state RUN, stall_cnt 0, all outputs 0 until inputs drive them; reset mid-MULDIV or EXC_DRAIN returns to RUN with no muldiv_go/cancel pulse.

Structure
REQ-029 State encoding and stage-count constants SHALL live in shared package pipe_pkg.
REQ-030 Single module; no sub-module instances.

Verification
REQ-031 load_use 1 cycle in RUN -> pc_stall=1, IF_ID_Stall=1, ID_EXE_Flush=1 that cycle only; stall_cnt 0->1.
REQ-032 muldiv_start, done 4 cycles later -> muldiv_go 1 cycle, EXE_MEM_Flush 4 cycles, release on done cycle, state RUN.
REQ-033 Done while dmem_stall high 3 more cycles -> MD_HOLD 3 cycles, MEM_WB_Flush=1 throughout, then release, no second muldiv_go.
REQ-034 exc_flush in MULDIV, ifetch_stall high 2 cycles -> muldiv_cancel 1 cycle, EXC_DRAIN 2 cycles, then 4 Flush + pc_redirect 1 cycle.
REQ-035 stall_cnt preset path to 0xFFFFFFFF, one stall cycle -> 0; rst asserted mid-MULDIV -> state RUN, all outputs 0.
